// File: rtl/iob_cache_perf_csr_pkg.sv
// iob_cache_perf_csr_pkg: CSR word offsets, CTRL/STATUS bit indices and FSM states for the perf CSR.
package iob_cache_perf_csr_pkg;
  localparam logic [2:0] CSR_CTRL    = 3'd0;
  localparam logic [2:0] CSR_STATUS  = 3'd1;
  localparam logic [2:0] CSR_RH_SNAP = 3'd2;
  localparam logic [2:0] CSR_RM_SNAP = 3'd3;
  localparam logic [2:0] CSR_WH_SNAP = 3'd4;
  localparam logic [2:0] CSR_WM_SNAP = 3'd5;
  localparam int CTRL_CLR  = 0;
  localparam int CTRL_SNAP = 1;
  localparam int ST_RH = 0;
  localparam int ST_RM = 1;
  localparam int ST_WH = 2;
  localparam int ST_WM = 3;
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
endpackage

// File: rtl/iob_cache_perf_csr_wrap_det.sv
// iob_cache_perf_csr_wrap_det: MSB-fall wrap detector with sticky flag, W1C and clear.
module iob_cache_perf_csr_wrap_det (
  input  logic clk_i,
  input  logic arst_i,
  input  logic msb,
  input  logic clr,
  input  logic mask,
  input  logic w1c,
  output logic flag
);
  logic msb_q;
  // A new wrap takes precedence over a simultaneous W1C of the same flag.
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      msb_q <= 1'b0;
      flag  <= 1'b0;
    end else if (clr) begin
      msb_q <= 1'b0;
      flag  <= 1'b0;
    end else begin
      msb_q <= msb;
      flag  <= (~mask & msb_q & ~msb) | (flag & ~w1c);
    end
endmodule

// File: rtl/iob_cache_perf_csr.sv
// iob_cache_perf_csr: IOb CSR reader for cache hit/miss counters with snapshot, clear pulse and wrap flags.
module iob_cache_perf_csr
  import iob_cache_perf_csr_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  input  logic [DATA_W-1:0]   read_hit_cnt_i,
  input  logic [DATA_W-1:0]   read_miss_cnt_i,
  input  logic [DATA_W-1:0]   write_hit_cnt_i,
  input  logic [DATA_W-1:0]   write_miss_cnt_i,
  output logic                reset_counters_o
);
  state_t state, state_n;
  logic [2:0] word;
  logic acc, wr, rd, ctrl_wr, clr_req, snap;
  logic clr_d;
  logic [3:0] w1c, msb, wrap;
  logic [DATA_W-1:0] rh_s, rm_s, wh_s, wm_s, rmux;
  logic unused;
  assign unused = ^{iob_addr_i, iob_wdata_i};
  assign word = iob_addr_i[4:2];
  assign iob_ready_o = state == IDLE;
  assign iob_rvalid_o = state == RESP;
  assign acc = iob_avalid_i & iob_ready_o;
  assign wr = acc & |iob_wstrb_i;
  assign rd = acc & ~|iob_wstrb_i;
  assign ctrl_wr = wr & (word == CSR_CTRL);
  assign clr_req = ctrl_wr & iob_wdata_i[CTRL_CLR];
  assign snap = ctrl_wr & iob_wdata_i[CTRL_SNAP];
  assign w1c = (wr & (word == CSR_STATUS)) ? iob_wdata_i[3:0] : 4'b0;
  assign msb = {write_miss_cnt_i[DATA_W-1], write_hit_cnt_i[DATA_W-1],
                read_miss_cnt_i[DATA_W-1], read_hit_cnt_i[DATA_W-1]};
  always_comb
    state_n = (state == RESP) ? IDLE : (rd ? RESP : IDLE);
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      reset_counters_o <= 1'b0;
      clr_d            <= 1'b0;
    end else begin
      reset_counters_o <= clr_req;
      clr_d            <= reset_counters_o;
    end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      rh_s <= '0;
      rm_s <= '0;
      wh_s <= '0;
      wm_s <= '0;
    end else if (snap) begin
      rh_s <= read_hit_cnt_i;
      rm_s <= read_miss_cnt_i;
      wh_s <= write_hit_cnt_i;
      wm_s <= write_miss_cnt_i;
    end
  // Counters fall to zero right after the clear pulse; that fall must not look like a wrap.
  for (genvar i = 0; i < 4; i++) begin : g_wd
    iob_cache_perf_csr_wrap_det u_wd (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .msb    (msb[i]),
      .clr    (clr_req),
      .mask   (reset_counters_o | clr_d),
      .w1c    (w1c[i]),
      .flag   (wrap[i])
    );
  end
  always_comb begin
    rmux = '0;
    case (word)
      CSR_STATUS:  rmux[3:0] = wrap;
      CSR_RH_SNAP: rmux = rh_s;
      CSR_RM_SNAP: rmux = rm_s;
      CSR_WH_SNAP: rmux = wh_s;
      CSR_WM_SNAP: rmux = wm_s;
      default:     rmux = '0;
    endcase
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) iob_rdata_o <= '0;
    else if (rd) iob_rdata_o <= rmux;
endmodule

// File: tb/tb_iob_cache_perf_csr.sv
// tb_iob_cache_perf_csr: directed self-checking bench with a read-data scoreboard.
module tb_iob_cache_perf_csr;
  logic clk = 0, arst = 1;
  logic avalid = 0;
  logic [4:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic ready, rvalid, rst_cnt;
  logic [31:0] rdata;
  logic [31:0] rh = 0, rm = 0, wh = 0, wm = 0;
  logic [31:0] sb[$];
  int n = 0, fails = 0;

  iob_cache_perf_csr dut (
    .clk_i(clk), .arst_i(arst), .iob_avalid_i(avalid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_ready_o(ready),
    .iob_rvalid_o(rvalid), .iob_rdata_o(rdata), .read_hit_cnt_i(rh),
    .read_miss_cnt_i(rm), .write_hit_cnt_i(wh), .write_miss_cnt_i(wm),
    .reset_counters_o(rst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avalid = 1; addr = a; wdata = d; wstrb = 4'hF;
    chk("wr_ready", {31'b0, ready}, 1);
    @(negedge clk);
    avalid = 0; wstrb = 0;
  endtask

  task automatic resp(input string tag);
    int k = 0;
    logic [31:0] e;
    while (!rvalid && k < 3) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, k, 0);
    chk(tag, rdata, e);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    avalid = 1; addr = a; wstrb = 0;
    sb.push_back(exp);
    chk({tag, "_ready"}, {31'b0, ready}, 1);
    @(negedge clk);
    avalid = 0;
    resp(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_pulse", {31'b0, rst_cnt}, 0);
    chk("rst_ready", {31'b0, ready}, 1);
    chk("rst_rdata", rdata, 0);
    arst = 0;
    // reset mid-read
    @(negedge clk);
    avalid = 1; addr = 5'h04; wstrb = 0;
    @(posedge clk);
    #1 avalid = 0;
    chk("midrd_rvalid_pre", {31'b0, rvalid}, 1);
    arst = 1;
    #1 chk("midrd_rvalid", {31'b0, rvalid}, 0);
    chk("midrd_pulse", {31'b0, rst_cnt}, 0);
    @(negedge clk) arst = 0;
    // reset cancels a pending clear pulse
    @(negedge clk);
    avalid = 1; addr = 5'h00; wdata = 1; wstrb = 4'hF;
    @(posedge clk);
    #1 avalid = 0; wstrb = 0;
    chk("clr_pre", {31'b0, rst_cnt}, 1);
    arst = 1;
    #1 chk("clr_cancel", {31'b0, rst_cnt}, 0);
    @(negedge clk) arst = 0;
    rd("status_after_rst", 5'h04, 0);
    // snapshot
    @(negedge clk);
    rh = 5; rm = 6; wh = 7; wm = 8;
    wr(5'h00, 32'h2);
    chk("snap_no_pulse", {31'b0, rst_cnt}, 0);
    rh = 1; rm = 2; wh = 3; wm = 4;
    rd("rh_snap", 5'h08, 5);
    rd("rm_snap", 5'h0C, 6);
    rd("wh_snap", 5'h10, 7);
    rd("wm_snap", 5'h14, 8);
    // clear pulse
    wr(5'h00, 32'h1);
    chk("clr_pulse_n1", {31'b0, rst_cnt}, 1);
    @(negedge clk);
    chk("clr_pulse_n2", {31'b0, rst_cnt}, 0);
    rh = 9;
    wr(5'h00, 32'h3);
    rh = 0;
    chk("clrsnap_pulse", {31'b0, rst_cnt}, 1);
    rd("clrsnap_rh", 5'h08, 9);
    rd("clrsnap_rm", 5'h0C, 2);
    // wrap detection and W1C
    @(negedge clk) rh = 32'hFFFF_FFFF;
    @(negedge clk) rh = 32'h0;
    @(negedge clk);
    rd("wrap_set", 5'h04, 1);
    wr(5'h04, 32'h1);
    rd("wrap_w1c", 5'h04, 0);
    @(negedge clk) rh = 32'hFFFF_FFFF;
    @(negedge clk);
    rh = 0; avalid = 1; addr = 5'h04; wdata = 1; wstrb = 4'hF;
    @(negedge clk);
    avalid = 0; wstrb = 0;
    rd("wrap_vs_w1c", 5'h04, 1);
    // clear-induced fall must be masked
    @(negedge clk) rh = 32'h8000_0000;
    @(negedge clk);
    wr(5'h00, 32'h1);
    chk("mask_pulse", {31'b0, rst_cnt}, 1);
    @(negedge clk);
    rh = 0;
    repeat (2) @(negedge clk);
    rd("mask_status", 5'h04, 0);
    // back-to-back reads
    @(negedge clk);
    avalid = 1; addr = 5'h08; wstrb = 0;
    sb.push_back(9);
    chk("b2b_ready0", {31'b0, ready}, 1);
    @(negedge clk);
    chk("b2b_ready_resp", {31'b0, ready}, 0);
    chk("b2b_rvalid1", {31'b0, rvalid}, 1);
    chk("b2b_rdata1", rdata, sb.pop_front());
    addr = 5'h0C;
    @(negedge clk);
    chk("b2b_ready2", {31'b0, ready}, 1);
    sb.push_back(2);
    @(negedge clk);
    avalid = 0;
    resp("b2b_rdata2");
    @(negedge clk);
    chk("hold_rvalid", {31'b0, rvalid}, 0);
    chk("hold_rdata", rdata, 2);
    // unmapped address
    rd("unmapped_rd", 5'h18, 0);
    wr(5'h18, 32'hFFFF_FFFF);
    chk("unmapped_pulse", {31'b0, rst_cnt}, 0);
    rd("unmapped_status", 5'h04, 0);
    rd("unmapped_rh", 5'h08, 9);
    rd("ctrl_rd", 5'h00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
